// File: rtl/cmdparse_pkg.sv
// Shared definitions for the burst command parser: state encoding, framing
// characters and record geometry.
package cmdparse_pkg;

    typedef enum logic [3:0] {
        GET_HDR,
        GET_SEQ,
        GET_COUNT,
        GET_FLAG,
        GET_ADR,
        GET_DAT,
        GET_CRC0,
        GET_CRC1,
        GET_TERM,
        SCAN_TERM,
        DRAIN
    } state_t;

    localparam logic [7:0] REQ_HDR   = 8'h52;
    localparam logic [7:0] SCAN_CHAR = 8'h7E;

    // Bytes per record: FLAG, then the address, then the data.
    function automatic int rec_len(input int addr_bytes, input int data_bytes);
        return 1 + addr_bytes + data_bytes;
    endfunction

endpackage

// File: rtl/cmdparse_buf.sv
// Command buffer of {we, adr, dat} entries; one write port, one read port
// addressed directly by the parser's write and read pointers.
module cmdparse_buf #(
    parameter int W     = 25,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [PW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem_reg[i] <= '0;
        end else if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // The parser registers this value into its output stage, so the read
    // path stays combinational to keep the drain free of bubbles.
    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/crc16ccitt.sv
// Bytewise CRC16-CCITT (poly 0x1021, MSB first, cleared to zero).
module crc16ccitt (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [15:0] crc
);

    logic [15:0] crc_reg;
    logic [15:0] crc_next;

    always_comb begin
        crc_next = crc_reg;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[15] ^ data[7-i])
                crc_next = {crc_next[14:0], 1'b0} ^ 16'h1021;
            else
                crc_next = {crc_next[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            crc_reg <= '0;
        else if (en)
            crc_reg <= crc_next;
    end

    assign crc = crc_reg;

endmodule

// File: rtl/cmdparse_burst.sv
// Framed multi-command request parser: buffers records until CRC and terminator
// validate, then drains them over a valid/ready handshake.
module cmdparse_burst
    import cmdparse_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int DATA_BYTES = 1,
    parameter int MAX_CMDS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_avail,
    output logic                    cmd_valid,
    input  logic                    cmd_ready,
    output logic [5:0]              seq_o,
    output logic                    we_o,
    output logic [8*ADDR_BYTES-1:0] adr_o,
    output logic [8*DATA_BYTES-1:0] dat_o,
    output logic                    last_o,
    output logic                    err_frame,
    output logic                    err_crc,
    output logic                    err_busy
);

    localparam int AW      = 8 * ADDR_BYTES;
    localparam int DW      = 8 * DATA_BYTES;
    localparam int EW      = 1 + AW + DW;
    localparam int PW      = (MAX_CMDS > 1) ? $clog2(MAX_CMDS) : 1;
    localparam int CW      = $clog2(MAX_CMDS + 1);
    localparam int REC_LEN = rec_len(ADDR_BYTES, DATA_BYTES);

    // Record byte positions: 0 = FLAG, 1..ADDR_BYTES = address, rest = data.
    localparam logic [3:0] ADR_LAST_POS = 4'(ADDR_BYTES);
    localparam logic [3:0] DAT_LAST_POS = 4'(REC_LEN - 1);
    localparam logic [8:0] MAX_CMDS_B   = 9'(MAX_CMDS);

    state_t          state_reg, state_next;
    logic [5:0]      seq_reg, seq_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [CW-1:0]   rec_cnt_reg, rec_cnt_next;
    logic [3:0]      pos_reg, pos_next;
    logic            we_reg, we_next;
    logic [AW-1:0]   adr_reg, adr_next;
    logic [DW-1:0]   dat_reg, dat_next;
    logic [PW-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]   rd_ptr_reg, rd_ptr_next;
    logic            drop_reg, drop_next;

    logic            cmd_valid_reg, cmd_valid_next;
    logic [5:0]      seq_o_reg, seq_o_next;
    logic            we_o_reg, we_o_next;
    logic [AW-1:0]   adr_o_reg, adr_o_next;
    logic [DW-1:0]   dat_o_reg, dat_o_next;
    logic            last_o_reg, last_o_next;
    logic            err_frame_reg, err_frame_next;
    logic            err_crc_reg, err_crc_next;
    logic            err_busy_reg, err_busy_next;

    logic            crc_clr, crc_en;
    logic [15:0]     crc_val;
    logic            buf_we;
    logic [EW-1:0]   buf_wdata, buf_rdata;
    logic [PW-1:0]   rd_addr;
    logic            load_out;
    logic            goto_scan;
    logic [1:0]      adr_idx, dat_idx;

    crc16ccitt u_crc (
        .clk  (clk),
        .rst  (rst),
        .clr  (crc_clr),
        .en   (crc_en),
        .data (rx_data),
        .crc  (crc_val)
    );

    assign buf_wdata = {we_reg, adr_reg, dat_next};

    cmdparse_buf #(
        .W     (EW),
        .DEPTH (MAX_CMDS),
        .PW    (PW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (buf_wdata),
        .rd_addr (rd_addr),
        .rd_data (buf_rdata)
    );

    always_comb begin
        state_next     = state_reg;
        seq_next       = seq_reg;
        count_next     = count_reg;
        rec_cnt_next   = rec_cnt_reg;
        pos_next       = pos_reg;
        we_next        = we_reg;
        adr_next       = adr_reg;
        dat_next       = dat_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        drop_next      = drop_reg;
        cmd_valid_next = cmd_valid_reg;
        seq_o_next     = seq_o_reg;
        we_o_next      = we_o_reg;
        adr_o_next     = adr_o_reg;
        dat_o_next     = dat_o_reg;
        last_o_next    = last_o_reg;
        err_frame_next = 1'b0;
        err_crc_next   = 1'b0;
        err_busy_next  = 1'b0;
        crc_clr        = 1'b0;
        crc_en         = 1'b0;
        buf_we         = 1'b0;
        rd_addr        = '0;
        load_out       = 1'b0;
        goto_scan      = 1'b0;
        adr_idx        = 2'(pos_reg - 4'd1);
        dat_idx        = 2'(pos_reg - ADR_LAST_POS - 4'd1);

        case (state_reg)
            GET_HDR: if (rx_avail) begin
                if (rx_data == REQ_HDR) begin
                    crc_en     = 1'b1;
                    state_next = GET_SEQ;
                end else begin
                    crc_clr = 1'b1;
                    if (rx_data != SCAN_CHAR) begin
                        err_frame_next = 1'b1;
                        goto_scan      = 1'b1;
                    end
                end
            end
            GET_SEQ: if (rx_avail) begin
                if (rx_data[7:6] != 2'b00) begin
                    err_frame_next = 1'b1;
                    goto_scan      = 1'b1;
                end else begin
                    seq_next   = rx_data[5:0];
                    crc_en     = 1'b1;
                    state_next = GET_COUNT;
                end
            end
            GET_COUNT: if (rx_avail) begin
                if (rx_data == 8'h00 || {1'b0, rx_data} > MAX_CMDS_B) begin
                    err_frame_next = 1'b1;
                    goto_scan      = 1'b1;
                end else begin
                    count_next   = CW'(rx_data);
                    rec_cnt_next = '0;
                    crc_en       = 1'b1;
                    state_next   = GET_FLAG;
                end
            end
            GET_FLAG: if (rx_avail) begin
                if (rx_data[6:0] != 7'd0) begin
                    err_frame_next = 1'b1;
                    goto_scan      = 1'b1;
                end else begin
                    we_next    = rx_data[7];
                    pos_next   = 4'd1;
                    crc_en     = 1'b1;
                    state_next = GET_ADR;
                end
            end
            GET_ADR: if (rx_avail) begin
                crc_en = 1'b1;
                for (int b = 0; b < ADDR_BYTES; b++)
                    if (adr_idx == 2'(b))
                        adr_next[b*8 +: 8] = rx_data;
                pos_next = pos_reg + 4'd1;
                if (pos_reg == ADR_LAST_POS)
                    state_next = GET_DAT;
            end
            GET_DAT: if (rx_avail) begin
                crc_en = 1'b1;
                for (int b = 0; b < DATA_BYTES; b++)
                    if (dat_idx == 2'(b))
                        dat_next[b*8 +: 8] = rx_data;
                pos_next = pos_reg + 4'd1;
                if (pos_reg == DAT_LAST_POS) begin
                    buf_we       = 1'b1;
                    wr_ptr_next  = wr_ptr_reg + PW'(1);
                    rec_cnt_next = rec_cnt_reg + CW'(1);
                    state_next   = (rec_cnt_reg == count_reg - CW'(1)) ? GET_CRC0 : GET_FLAG;
                end
            end
            GET_CRC0: if (rx_avail) begin
                if (rx_data != crc_val[15:8]) begin
                    err_crc_next = 1'b1;
                    goto_scan    = 1'b1;
                end else begin
                    state_next = GET_CRC1;
                end
            end
            GET_CRC1: if (rx_avail) begin
                if (rx_data != crc_val[7:0]) begin
                    err_crc_next = 1'b1;
                    goto_scan    = 1'b1;
                end else begin
                    state_next = GET_TERM;
                end
            end
            GET_TERM: begin
                crc_clr = 1'b1;
                if (rx_avail) begin
                    if (rx_data == SCAN_CHAR) begin
                        // Commit: present entry 0 on the very next cycle.
                        wr_ptr_next    = '0;
                        rd_ptr_next    = '0;
                        rd_addr        = '0;
                        load_out       = 1'b1;
                        cmd_valid_next = 1'b1;
                        seq_o_next     = seq_reg;
                        drop_next      = 1'b0;
                        state_next     = DRAIN;
                    end else begin
                        err_frame_next = 1'b1;
                        goto_scan      = 1'b1;
                    end
                end
            end
            SCAN_TERM: begin
                crc_clr = 1'b1;
                if (rx_avail && rx_data == SCAN_CHAR)
                    state_next = GET_HDR;
            end
            DRAIN: begin
                if (rx_avail) begin
                    drop_next = 1'b1;
                    if (rx_data == REQ_HDR)
                        err_busy_next = 1'b1;
                end
                if (cmd_valid_reg && cmd_ready) begin
                    if (last_o_reg) begin
                        cmd_valid_next = 1'b0;
                        drop_next      = 1'b0;
                        state_next     = (drop_reg || rx_avail) ? SCAN_TERM : GET_HDR;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + PW'(1);
                        rd_addr     = rd_ptr_reg + PW'(1);
                        load_out    = 1'b1;
                    end
                end
            end
            default: state_next = GET_HDR;
        endcase

        if (goto_scan) begin
            state_next  = SCAN_TERM;
            wr_ptr_next = '0;
        end

        if (load_out) begin
            {we_o_next, adr_o_next, dat_o_next} = buf_rdata;
            last_o_next = (CW'(rd_addr) == count_reg - CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= GET_HDR;
            seq_reg       <= '0;
            count_reg     <= '0;
            rec_cnt_reg   <= '0;
            pos_reg       <= '0;
            we_reg        <= 1'b0;
            adr_reg       <= '0;
            dat_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            drop_reg      <= 1'b0;
            cmd_valid_reg <= 1'b0;
            seq_o_reg     <= '0;
            we_o_reg      <= 1'b0;
            adr_o_reg     <= '0;
            dat_o_reg     <= '0;
            last_o_reg    <= 1'b0;
            err_frame_reg <= 1'b0;
            err_crc_reg   <= 1'b0;
            err_busy_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            seq_reg       <= seq_next;
            count_reg     <= count_next;
            rec_cnt_reg   <= rec_cnt_next;
            pos_reg       <= pos_next;
            we_reg        <= we_next;
            adr_reg       <= adr_next;
            dat_reg       <= dat_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            drop_reg      <= drop_next;
            cmd_valid_reg <= cmd_valid_next;
            seq_o_reg     <= seq_o_next;
            we_o_reg      <= we_o_next;
            adr_o_reg     <= adr_o_next;
            dat_o_reg     <= dat_o_next;
            last_o_reg    <= last_o_next;
            err_frame_reg <= err_frame_next;
            err_crc_reg   <= err_crc_next;
            err_busy_reg  <= err_busy_next;
        end
    end

    assign cmd_valid = cmd_valid_reg;
    assign seq_o     = seq_o_reg;
    assign we_o      = we_o_reg;
    assign adr_o     = adr_o_reg;
    assign dat_o     = dat_o_reg;
    assign last_o    = last_o_reg;
    assign err_frame = err_frame_reg;
    assign err_crc   = err_crc_reg;
    assign err_busy  = err_busy_reg;

endmodule

// File: doc/cmdparse_burst.md
# cmdparse_burst

Parametrised successor to the single-command serial message parser. It accepts framed request messages from the UART receive byte stream. Each message carries 1..MAX_CMDS read/write commands of configurable address and data width. Commands are held in an internal buffer until the frame's CRC16 and terminator validate, then released to the bus-command side under a valid/ready handshake. It sits between the UART receiver and the command executor and adds error reporting and back-pressure.

## Interface
- ADDR_BYTES, 2: address bytes per command (1..4); address width AW = 8*ADDR_BYTES.
- DATA_BYTES, 1: data bytes per command (1..4); data width DW = 8*DATA_BYTES.
- MAX_CMDS, 4: maximum commands per message and the command buffer depth (power of two, 1..16).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte.
- rx_avail  in  1  one-cycle strobe; rx_data is valid.
- cmd_valid  out  1  buffered command presented.
- cmd_ready  in  1  consumer accepts the command when cmd_valid && cmd_ready.
- seq_o  out  6  sequence number of the message being drained.
- we_o  out  1  1 = write, 0 = read.
- adr_o  out  AW  command address.
- dat_o  out  DW  command write data.
- last_o  out  1  the presented command is the final one of its message.
- err_frame  out  1  one-cycle pulse on a framing or format violation.
- err_crc  out  1  one-cycle pulse on a CRC mismatch.
- err_busy  out  1  one-cycle pulse when REQ_HDR arrives while the buffer is still draining.

## Operation
- Frame format: REQ_HDR 0x52, SEQ (bits 7:6 = 0), COUNT (1..MAX_CMDS), then COUNT records, then CRC_HI, CRC_LO, SCAN_CHAR 0x7E.
- Record format: FLAG (bit7 = we, bits 6:0 = 0), ADDR little-endian, DATA little-endian.
- State machine states: GET_HDR, GET_SEQ, GET_COUNT, GET_FLAG, GET_ADR, GET_DAT, GET_CRC0, GET_CRC1, GET_TERM, SCAN_TERM, DRAIN.
  - The state machine advances only on rx_avail.
  - A byte counter tracks position within ADR/DAT.
  - A record counter tracks the number of records received against COUNT.
- GET_HDR: 0x52 goes to GET_SEQ; 0x7E stays in GET_HDR (idle fill); any other byte goes to SCAN_TERM with err_frame.
- The following go to SCAN_TERM with err_frame: a SEQ byte with bits 7:6 nonzero, COUNT = 0, COUNT > MAX_CMDS, a FLAG byte with bits 6:0 nonzero, or a wrong terminator.
- Records are written to the buffer at wr_ptr as they complete.
- On any transition to SCAN_TERM, wr_ptr returns to 0 and no partial message is ever presented.
- CRC:
  - Uses the crc16ccitt sub-module (poly 0x1021).
  - Fed every byte from HDR through the last DATA byte.
  - Cleared in GET_TERM, in SCAN_TERM, and on a non-0x52 byte in GET_HDR.
  - Compared high byte first. A mismatch raises err_crc and goes to SCAN_TERM.
- SCAN_TERM: waits for 0x7E, then goes to GET_HDR.
- GET_TERM with 0x7E commits COUNT entries and enters DRAIN.
- DRAIN:
  - Entries are presented in arrival order. Each handshake advances rd_ptr.
  - last_o = 1 on entry COUNT-1.
  - The handshake on the last entry returns the state to GET_HDR.
  - Bytes arriving in DRAIN are discarded. A 0x52 byte also pulses err_busy.
  - After any discarded byte the state goes to SCAN_TERM once draining completes.

## Timing
- Reset values: all outputs 0; state GET_HDR; wr_ptr = rd_ptr = 0; CRC cleared. rst dominates rx_avail and cmd_ready.
- cmd_valid rises on the clock after the edge at which the terminating 0x7E is sampled (1-cycle latency).
- While cmd_valid is high, seq_o, we_o, adr_o, dat_o and last_o are stable until the handshake.
- The next entry is presented on the following clock with zero bubble; back-to-back handshakes sustain 1 command per cycle.
- Error pulses are registered and appear 1 cycle after the offending byte.
- Back-pressure: cmd_ready may be held low indefinitely. The parser never drops committed commands.
- Reset mid-DRAIN: cmd_valid = 0 on the next edge and buffer contents are discarded.

## Structure
- Shared package cmdparse_pkg holds:
  - the state encoding;
  - REQ_HDR and SCAN_CHAR;
  - record length 1+ADDR_BYTES+DATA_BYTES.
- Sub-module cmdparse_buf: a MAX_CMDS-entry register buffer of {we, adr, dat} with a write port and a read port. It is indexed by the parser's pointers.
- crc16ccitt is reused unchanged.

## Test plan
- Single write: 52 05 01 80 34 12 AB crc 7E → cmd_valid the next cycle with seq_o=5, we_o=1, adr_o=0x1234, dat_o=0xAB, last_o=1; one handshake and the parser is back in GET_HDR.
- Burst: COUNT=4 (reads at 0x0010..0x0013) with cmd_ready toggling 1,0,1,1,0,1 → four commands in order, last_o only on 0x0013, no loss and no duplication.
- Bad CRC: a valid 2-record frame with CRC_LO^0x01 → err_crc pulse, no cmd_valid; a following good frame is accepted normally.
- Format errors:
  - COUNT=0 → err_frame; resync on 7E.
  - COUNT=MAX_CMDS+1 → err_frame; resync on 7E.
  - FLAG=0x81 → err_frame; resync on 7E.
- Busy: a new 52 frame arrives while 3 commands are still undrained with cmd_ready=0 → err_busy, remaining commands unaffected, the new frame is dropped.
- Reset: assert rst during GET_DAT and again during DRAIN → outputs 0 next edge; a subsequent good frame parses correctly.
